pipe_sequencer: RTL
===================

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 1024, meaning instruction-memory size in words.
REQ-002 SHALL have parameter HLT_OPCODE, default 6'b111111, meaning the opcode that stops fetch.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, meaning cycles allowed for in-flight instructions to retire after fetch stops.
REQ-004 SHALL have port clk, input, 1, the single clock; every flop is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, a load/run request honoured only in IDLE or HALTED.
REQ-007 SHALL have port stop, input, 1, a request honoured only in RUN; it forces a drain.
REQ-008 SHALL have port ld_valid, input, 1, indicating a program word is offered.
REQ-009 SHALL have port ld_data, input, 32, the program word.
REQ-010 SHALL have port ld_last, input, 1, marking the final program word; it is qualified by ld_valid.
REQ-011 SHALL have port ld_ready, output, 1, indicating the sequencer accepts a program word.
REQ-012 SHALL have port imem_we, output, 1, the instruction-memory write strobe.
REQ-013 SHALL have port imem_waddr, output, 10, the instruction-memory word address.
REQ-014 SHALL have port imem_wdata, output, 32, the instruction-memory write data.
REQ-015 SHALL have port if_opcode, input, 6, bits [31:26] of the IF-stage fetched instruction.
REQ-016 SHALL have port pc_en, output, 1, which lets the PC register update.
REQ-017 SHALL have port pc_clr, output, 1, which forces the PC to 0.
REQ-018 SHALL have port pipe_flush, output, 1, which forces bubbles into all pipeline registers.
REQ-019 SHALL have port busy, output, 1, high in LOAD, CLEAR, RUN and DRAIN.
REQ-020 SHALL have port halted, output, 1, high in HALTED.
REQ-021 SHALL have port err_ovf, output, 1, a sticky overflow flag for program loads.
REQ-022 SHALL have port run_cycles, output, 32, the count of cycles spent in RUN.

Function
REQ-023 SHALL implement states IDLE, LOAD, CLEAR, RUN, DRAIN and HALTED.
REQ-024 SHALL transition IDLE->LOAD and HALTED->LOAD on start=1; entering LOAD clears the word counter, err_ovf, run_cycles and halted.
REQ-025 SHALL drive ld_ready=1 in LOAD only; a beat is accepted when ld_valid&ld_ready.
REQ-026 SHALL register each accepted beat: the next cycle imem_we=1, imem_waddr=count and imem_wdata=ld_data, and count increments.
REQ-027 SHALL, when a beat is accepted with count==IMEM_DEPTH, drop it (no imem_we) and set err_ovf.
REQ-028 SHALL move LOAD->CLEAR on accepting a beat with ld_last=1, so the final write happens during CLEAR.
REQ-029 SHALL hold CLEAR for exactly 1 cycle with pc_clr=1 and pipe_flush=1, then go to RUN.
REQ-030 SHALL drive pc_en=1 and pipe_flush=0 in RUN, and increment run_cycles by 1 each RUN cycle, saturating at all-ones.
REQ-031 SHALL move RUN->DRAIN when if_opcode==HLT_OPCODE or stop=1; both together count as one event.
REQ-032 SHALL hold pc_en=0 and pipe_flush=0 in DRAIN for exactly DRAIN_CYCLES cycles, then go to HALTED.
REQ-033 SHALL drive pc_en=0 and pipe_flush=1 in HALTED and IDLE.
REQ-034 SHALL ignore start in LOAD, CLEAR, RUN and DRAIN, and ignore stop outside RUN.
REQ-035 SHALL give start priority when start and stop are both high in HALTED.
REQ-036 SHALL drive imem_we=0 in every state except the cycle after an accepted in-range beat.

Reset
REQ-037 SHALL, while rst_n=0, immediately force state IDLE, pc_en=0, pc_clr=0, pipe_flush=1, ld_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, halted=0, err_ovf=0, run_cycles=0 and counters=0.
REQ-038 SHALL abandon any pending registered write when reset is asserted mid-load; no imem_we follows reset release.
REQ-039 SHALL remain in IDLE after reset until start=1.

Structure
REQ-040 SHALL place the state encodings, HLT_OPCODE default and DRAIN_CYCLES default in shared package mips_ctrl_pkg.
REQ-041 SHALL be one module with no sub-modules; the counters are inline.

Verification
REQ-042 SHALL cover: start, then 3 beats 0x20010005, 0x20020007, 0xFC000000 (last) -> imem writes at addresses 0,1,2; one pc_clr pulse; RUN with pc_en=1; HALT fetch -> DRAIN for 4 cycles -> halted=1.
REQ-043 SHALL cover: ld_valid toggled every other cycle -> writes remain contiguous at addresses 0..N-1 with no duplicates.
REQ-044 SHALL cover: with IMEM_DEPTH=4, load 6 beats -> exactly 4 writes and err_ovf=1.
REQ-045 SHALL cover: stop=1 on the 10th RUN cycle -> run_cycles=10 and DRAIN entered the next cycle.
REQ-046 SHALL cover: rst_n=0 during LOAD after 2 beats -> outputs at reset values immediately and no further imem_we.
REQ-047 SHALL cover: start pulse during RUN -> ignored; start in HALTED -> LOAD with err_ovf and run_cycles cleared.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline control sequencer.
// Both the RTL and its bench import this package.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_HALTED = 3'd5
    } seqState_e;

    localparam logic [5:0]  HLT_OPCODE_DEFAULT   = 6'b111111;
    localparam int unsigned DRAIN_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/pipe_sequencer.sv
// Program-load and run/halt sequencer for a small pipelined core.
// It loads instruction memory, clears the pipe, runs, then drains and halts.
module pipe_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH   = 1024,
    parameter logic [5:0]  HLT_OPCODE   = HLT_OPCODE_DEFAULT,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        imem_we,
    output logic [9:0]  imem_waddr,
    output logic [31:0] imem_wdata,
    input  logic [5:0]  if_opcode,
    output logic        pc_en,
    output logic        pc_clr,
    output logic        pipe_flush,
    output logic        busy,
    output logic        halted,
    output logic        err_ovf,
    output logic [31:0] run_cycles
);

    localparam int CNT_W = $clog2(IMEM_DEPTH + 1);
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    seqState_e          state_q, state_d;
    logic [CNT_W-1:0]   wordCnt_q, wordCnt_d;
    logic               wrPend_q, wrPend_d;
    logic [9:0]         wrAddr_q, wrAddr_d;
    logic [31:0]        wrData_q, wrData_d;
    logic               errOvf_q, errOvf_d;
    logic [31:0]        runCycles_q, runCycles_d;
    logic [DRN_W-1:0]   drainCnt_q, drainCnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wordCnt_q   <= '0;
            wrPend_q    <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            errOvf_q    <= 1'b0;
            runCycles_q <= '0;
            drainCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wordCnt_q   <= wordCnt_d;
            wrPend_q    <= wrPend_d;
            wrAddr_q    <= wrAddr_d;
            wrData_q    <= wrData_d;
            errOvf_q    <= errOvf_d;
            runCycles_q <= runCycles_d;
            drainCnt_q  <= drainCnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wordCnt_d   = wordCnt_q;
        wrPend_d    = 1'b0;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;
        errOvf_d    = errOvf_q;
        runCycles_d = runCycles_q;
        drainCnt_d  = drainCnt_q;
        ld_ready    = 1'b0;
        pc_en       = 1'b0;
        pc_clr      = 1'b0;
        pipe_flush  = 1'b1;
        busy        = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                halted = (state_q == ST_HALTED);
                if (start) begin
                    state_d     = ST_LOAD;
                    wordCnt_d   = '0;
                    errOvf_d    = 1'b0;
                    runCycles_d = '0;
                end
            end
            ST_LOAD: begin
                busy     = 1'b1;
                ld_ready = 1'b1;
                if (ld_valid) begin
                    // A full memory swallows the beat but still honours ld_last.
                    if (wordCnt_q == CNT_W'(IMEM_DEPTH)) begin
                        errOvf_d = 1'b1;
                    end else begin
                        wrPend_d  = 1'b1;
                        wrAddr_d  = 10'(wordCnt_q);
                        wrData_d  = ld_data;
                        wordCnt_d = wordCnt_q + CNT_W'(1);
                    end
                    if (ld_last) begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                busy    = 1'b1;
                pc_clr  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                busy       = 1'b1;
                pc_en      = 1'b1;
                pipe_flush = 1'b0;
                if (runCycles_q != '1) begin
                    runCycles_d = runCycles_q + 32'd1;
                end
                if (stop || (if_opcode == HLT_OPCODE)) begin
                    state_d    = ST_DRAIN;
                    drainCnt_d = '0;
                end
            end
            ST_DRAIN: begin
                busy       = 1'b1;
                pipe_flush = 1'b0;
                if (drainCnt_q == DRN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_HALTED;
                end else begin
                    drainCnt_d = drainCnt_q + DRN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_we    = wrPend_q;
    assign imem_waddr = wrAddr_q;
    assign imem_wdata = wrData_q;
    assign err_ovf    = errOvf_q;
    assign run_cycles = runCycles_q;

endmodule
